// File: rtl/mem_bus_arbiter_if.sv
// Pipeline-side request/response and memory-side bus signals of the instruction/data bus arbiter.
// Modport slave is the arbiter view; modport master is the pipeline and memory view.
interface mem_bus_arbiter_if;
   logic        ireq_valid;
   logic [63:0] ireq_addr;
   logic        iresp_data_ok;
   logic [31:0] iresp_data;

   logic        dreq_valid;
   logic        dreq_write;
   logic [63:0] dreq_addr;
   logic [2:0]  dreq_size;
   logic [7:0]  dreq_strobe;
   logic [63:0] dreq_data;
   logic        dresp_data_ok;
   logic [63:0] dresp_data;

   logic        mreq_valid;
   logic        mreq_is_write;
   logic [63:0] mreq_addr;
   logic [2:0]  mreq_size;
   logic [7:0]  mreq_strobe;
   logic [63:0] mreq_data;
   logic        mresp_ready;
   logic [63:0] mresp_data;

   modport slave (
      input  ireq_valid, ireq_addr,
      input  dreq_valid, dreq_write, dreq_addr, dreq_size, dreq_strobe, dreq_data,
      input  mresp_ready, mresp_data,
      output iresp_data_ok, iresp_data,
      output dresp_data_ok, dresp_data,
      output mreq_valid, mreq_is_write, mreq_addr, mreq_size, mreq_strobe, mreq_data
   );

   modport master (
      output ireq_valid, ireq_addr,
      output dreq_valid, dreq_write, dreq_addr, dreq_size, dreq_strobe, dreq_data,
      output mresp_ready, mresp_data,
      input  iresp_data_ok, iresp_data,
      input  dresp_data_ok, dresp_data,
      input  mreq_valid, mreq_is_write, mreq_addr, mreq_size, mreq_strobe, mreq_data
   );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Single-outstanding arbiter between fetch and data requesters onto one memory bus; grant lands on the bus one cycle after sampling.
// Bus stalls hold the latched request until mresp_ready; data wins ties unless fetch has waited STARVE_LIMIT (>= 1) data grants.
module mem_bus_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic             clk,
   input  logic             reset,
   mem_bus_arbiter_if.slave bus
);
   localparam int unsigned   SW    = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] I_BUSY = 2'd1;
   localparam logic [1:0] D_BUSY = 2'd2;

   logic [1:0]    state;
   logic [SW-1:0] streak;
   logic          valid_q;
   logic          is_write_q;
   logic [63:0]   addr_q;
   logic [2:0]    size_q;
   logic [7:0]    strobe_q;
   logic [63:0]   data_q;
   logic          grant_d;
   logic          grant_i;
   logic          done;

   assign grant_d = bus.dreq_valid && (!bus.ireq_valid || (streak < LIMIT));
   assign grant_i = !grant_d && bus.ireq_valid;

   // Gated by reset so a transaction aborted by reset never reports completion.
   assign done = reset && bus.mresp_ready && ((state == I_BUSY) || (state == D_BUSY));

   assign bus.iresp_data_ok = done && (state == I_BUSY);
   assign bus.dresp_data_ok = done && (state == D_BUSY);
   assign bus.iresp_data    = !bus.iresp_data_ok ? 32'd0 :
                              (addr_q[2] ? bus.mresp_data[63:32] : bus.mresp_data[31:0]);
   assign bus.dresp_data    = bus.dresp_data_ok ? bus.mresp_data : 64'd0;

   assign bus.mreq_valid    = valid_q;
   assign bus.mreq_is_write = is_write_q;
   assign bus.mreq_addr     = addr_q;
   assign bus.mreq_size     = size_q;
   assign bus.mreq_strobe   = strobe_q;
   assign bus.mreq_data     = data_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= IDLE;
         streak     <= '0;
         valid_q    <= 1'b0;
         is_write_q <= 1'b0;
         addr_q     <= 64'd0;
         size_q     <= 3'd0;
         strobe_q   <= 8'd0;
         data_q     <= 64'd0;
      end else begin
         case (state)
            IDLE: begin
               if (!bus.ireq_valid || grant_i) begin
                  streak <= '0;
               end else if (grant_d && (streak != LIMIT)) begin
                  streak <= streak + 1'b1;
               end
               if (grant_d) begin
                  state      <= D_BUSY;
                  valid_q    <= 1'b1;
                  is_write_q <= bus.dreq_write;
                  addr_q     <= bus.dreq_addr;
                  size_q     <= bus.dreq_size;
                  strobe_q   <= bus.dreq_strobe;
                  data_q     <= bus.dreq_data;
               end else if (grant_i) begin
                  state      <= I_BUSY;
                  valid_q    <= 1'b1;
                  is_write_q <= 1'b0;
                  addr_q     <= bus.ireq_addr;
                  size_q     <= 3'd3;
                  strobe_q   <= 8'd0;
                  data_q     <= 64'd0;
               end
            end
            I_BUSY, D_BUSY: begin
               if (bus.mresp_ready) begin
                  valid_q <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed scenarios followed by a randomized run against a transaction-level arbitration model.
module tb_mem_bus_arbiter;
   localparam int LIM = 4;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   mem_bus_arbiter_if bus();

   mem_bus_arbiter #(.STARVE_LIMIT(LIM)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic mid;
      @(negedge clk);
   endtask

   // Reference model state for the randomized run
   bit          m_busy;
   bit          m_own_d;
   int          m_streak;
   bit          i_done;
   bit          d_done;
   logic        e_wr;
   logic [63:0] e_addr;
   logic [2:0]  e_size;
   logic [7:0]  e_strb;
   logic [63:0] e_data;
   logic [63:0] exp_i;
   bit          ord [10];
   bit          exp_ord [10];
   int          n;

   initial begin
      exp_ord = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      reset = 1'b0;
      bus.ireq_valid  = 1'b0; bus.ireq_addr  = 64'd0;
      bus.dreq_valid  = 1'b0; bus.dreq_write = 1'b0; bus.dreq_addr = 64'd0;
      bus.dreq_size   = 3'd0; bus.dreq_strobe = 8'd0; bus.dreq_data = 64'd0;
      bus.mresp_ready = 1'b1; bus.mresp_data = 64'hDEAD_BEEF_CAFE_F00D;
      tick; tick;
      mid;
      chk("rst_mreq_valid", 64'(bus.mreq_valid), 64'd0);
      chk("rst_mreq_addr", bus.mreq_addr, 64'd0);
      chk("rst_iresp_ok", 64'(bus.iresp_data_ok), 64'd0);
      chk("rst_dresp_ok", 64'(bus.dresp_data_ok), 64'd0);
      chk("rst_dresp_data", bus.dresp_data, 64'd0);
      tick;
      reset = 1'b1;
      bus.mresp_ready = 1'b0;

      // 1: fetch only, upper word
      bus.ireq_valid = 1'b1; bus.ireq_addr = 64'h8000_0004;
      tick;
      mid;
      chk("t1_mreq_valid", 64'(bus.mreq_valid), 64'd1);
      chk("t1_mreq_size", 64'(bus.mreq_size), 64'd3);
      chk("t1_mreq_strobe", 64'(bus.mreq_strobe), 64'd0);
      chk("t1_mreq_wr", 64'(bus.mreq_is_write), 64'd0);
      chk("t1_mreq_addr", bus.mreq_addr, 64'h8000_0004);
      chk("t1_iresp_ok_early", 64'(bus.iresp_data_ok), 64'd0);
      tick;
      bus.mresp_ready = 1'b1; bus.mresp_data = 64'hAABB_CCDD_1122_3344;
      mid;
      chk("t1_iresp_ok", 64'(bus.iresp_data_ok), 64'd1);
      chk("t1_iresp_data", 64'(bus.iresp_data), 64'hAABB_CCDD);
      chk("t1_dresp_ok", 64'(bus.dresp_data_ok), 64'd0);
      tick;
      bus.ireq_valid = 1'b0; bus.mresp_ready = 1'b0;
      mid;
      chk("t1_iresp_ok_after", 64'(bus.iresp_data_ok), 64'd0);
      chk("t1_mreq_valid_after", 64'(bus.mreq_valid), 64'd0);

      // 2: simultaneous requests, data first
      bus.ireq_valid = 1'b1; bus.ireq_addr = 64'h8000_0008;
      bus.dreq_valid = 1'b1; bus.dreq_write = 1'b1; bus.dreq_addr = 64'h100;
      bus.dreq_size = 3'd4; bus.dreq_strobe = 8'hFF; bus.dreq_data = 64'h0123_4567_89AB_CDEF;
      tick;
      bus.mresp_ready = 1'b1; bus.mresp_data = 64'h5555_6666_7777_8888;
      mid;
      chk("t2_mreq_wr", 64'(bus.mreq_is_write), 64'd1);
      chk("t2_mreq_addr", bus.mreq_addr, 64'h100);
      chk("t2_mreq_size", 64'(bus.mreq_size), 64'd4);
      chk("t2_mreq_strobe", 64'(bus.mreq_strobe), 64'hFF);
      chk("t2_mreq_data", bus.mreq_data, 64'h0123_4567_89AB_CDEF);
      chk("t2_dresp_ok", 64'(bus.dresp_data_ok), 64'd1);
      chk("t2_dresp_data", bus.dresp_data, 64'h5555_6666_7777_8888);
      chk("t2_iresp_ok_d", 64'(bus.iresp_data_ok), 64'd0);
      tick;
      bus.dreq_valid = 1'b0; bus.mresp_ready = 1'b0;
      mid;
      chk("t2_idle_gap", 64'(bus.mreq_valid), 64'd0);
      tick;
      bus.mresp_ready = 1'b1;
      mid;
      chk("t2_i_addr", bus.mreq_addr, 64'h8000_0008);
      chk("t2_i_ok", 64'(bus.iresp_data_ok), 64'd1);
      chk("t2_i_data", 64'(bus.iresp_data), 64'h7777_8888);
      tick;
      bus.ireq_valid = 1'b0; bus.mresp_ready = 1'b0;

      // 3: starvation bound, both requesters saturating the bus
      bus.ireq_valid = 1'b1; bus.ireq_addr = 64'h8000_0010;
      bus.dreq_valid = 1'b1; bus.dreq_write = 1'b0; bus.dreq_addr = 64'h200; bus.dreq_size = 3'd3;
      bus.mresp_ready = 1'b1;
      n = 0;
      for (int c = 0; c < 60 && n < 10; c++) begin
         mid;
         if (bus.dresp_data_ok) begin ord[n] = 1'b1; n++; end
         else if (bus.iresp_data_ok) begin ord[n] = 1'b0; n++; end
         if (n < 10) tick;
      end
      chk("t3_grant_count", 64'(n), 64'd10);
      for (int k = 0; k < 10; k++) chk($sformatf("t3_grant%0d_is_d", k), 64'(ord[k]), 64'(exp_ord[k]));
      tick;
      bus.ireq_valid = 1'b0; bus.mresp_ready = 1'b0;

      // 4: bus stall with the requester wiggling its address
      bus.dreq_valid = 1'b1; bus.dreq_addr = 64'h300;
      tick;
      for (int k = 0; k < 5; k++) begin
         bus.dreq_addr = bus.dreq_addr ^ 64'hFF0;
         mid;
         chk("t4_stall_addr", bus.mreq_addr, 64'h300);
         chk("t4_stall_valid", 64'(bus.mreq_valid), 64'd1);
         chk("t4_stall_ok", 64'(bus.dresp_data_ok), 64'd0);
         tick;
      end
      bus.mresp_ready = 1'b1; bus.mresp_data = 64'h1111_2222_3333_4444;
      mid;
      chk("t4_ok", 64'(bus.dresp_data_ok), 64'd1);
      chk("t4_data", bus.dresp_data, 64'h1111_2222_3333_4444);
      tick;
      bus.dreq_valid = 1'b0; bus.mresp_ready = 1'b0;
      mid;
      chk("t4_ok_single", 64'(bus.dresp_data_ok), 64'd0);

      // 5: reset in the second busy cycle
      bus.dreq_valid = 1'b1; bus.dreq_addr = 64'h400;
      tick;
      mid;
      chk("t5_busy", 64'(bus.mreq_valid), 64'd1);
      tick;
      reset = 1'b0; bus.mresp_ready = 1'b1; bus.mresp_data = 64'h9999_AAAA_BBBB_CCCC;
      mid;
      chk("t5_no_ok_in_reset", 64'(bus.dresp_data_ok), 64'd0);
      chk("t5_no_data_in_reset", bus.dresp_data, 64'd0);
      tick;
      reset = 1'b1; bus.dreq_valid = 1'b0; bus.mresp_ready = 1'b0;
      mid;
      chk("t5_valid_cleared", 64'(bus.mreq_valid), 64'd0);
      chk("t5_addr_cleared", bus.mreq_addr, 64'd0);

      // 6: lower-word fetch straight after reset
      bus.ireq_valid = 1'b1; bus.ireq_addr = 64'h8000_0000;
      tick;
      bus.mresp_ready = 1'b1; bus.mresp_data = 64'hAABB_CCDD_1122_3344;
      mid;
      chk("t6_addr", bus.mreq_addr, 64'h8000_0000);
      chk("t6_ok", 64'(bus.iresp_data_ok), 64'd1);
      chk("t6_data", 64'(bus.iresp_data), 64'h1122_3344);
      tick;
      bus.ireq_valid = 1'b0; bus.mresp_ready = 1'b0;

      // Randomized run from a fresh reset
      reset = 1'b0;
      tick;
      reset = 1'b1;
      m_busy = 1'b0; m_own_d = 1'b0; m_streak = 0; i_done = 1'b0; d_done = 1'b0;
      for (int cyc = 0; cyc < 800; cyc++) begin
         if (i_done || !bus.ireq_valid) begin
            bus.ireq_valid = ($urandom_range(0, 1) == 1);
            bus.ireq_addr  = {32'h0, $urandom} & ~64'h3;
         end
         if (d_done || !bus.dreq_valid) begin
            bus.dreq_valid  = ($urandom_range(0, 1) == 1);
            bus.dreq_write  = ($urandom_range(0, 1) == 1);
            bus.dreq_addr   = {$urandom, $urandom};
            bus.dreq_size   = 3'($urandom_range(1, 4));
            bus.dreq_strobe = 8'($urandom);
            bus.dreq_data   = {$urandom, $urandom};
         end
         bus.mresp_ready = ($urandom_range(0, 2) == 0);
         bus.mresp_data  = {$urandom, $urandom};
         i_done = 1'b0; d_done = 1'b0;
         mid;
         if (m_busy) begin
            chk("r_mreq_valid", 64'(bus.mreq_valid), 64'd1);
            chk("r_mreq_wr", 64'(bus.mreq_is_write), 64'(e_wr));
            chk("r_mreq_addr", bus.mreq_addr, e_addr);
            chk("r_mreq_size", 64'(bus.mreq_size), 64'(e_size));
            chk("r_mreq_strobe", 64'(bus.mreq_strobe), 64'(e_strb));
            chk("r_mreq_data", bus.mreq_data, e_data);
            if (bus.mresp_ready) begin
               exp_i = e_addr[2] ? (bus.mresp_data >> 32) : (bus.mresp_data & 64'hFFFF_FFFF);
               chk("r_dresp_ok", 64'(bus.dresp_data_ok), 64'(m_own_d));
               chk("r_iresp_ok", 64'(bus.iresp_data_ok), 64'(!m_own_d));
               chk("r_dresp_data", bus.dresp_data, m_own_d ? bus.mresp_data : 64'd0);
               chk("r_iresp_data", 64'(bus.iresp_data), m_own_d ? 64'd0 : exp_i);
               if (m_own_d) d_done = 1'b1;
               else i_done = 1'b1;
               m_busy = 1'b0;
            end else begin
               chk("r_stall_dok", 64'(bus.dresp_data_ok), 64'd0);
               chk("r_stall_iok", 64'(bus.iresp_data_ok), 64'd0);
            end
         end else begin
            chk("r_idle_valid", 64'(bus.mreq_valid), 64'd0);
            chk("r_idle_dok", 64'(bus.dresp_data_ok), 64'd0);
            chk("r_idle_iok", 64'(bus.iresp_data_ok), 64'd0);
            chk("r_idle_idata", 64'(bus.iresp_data), 64'd0);
            if (bus.dreq_valid && (!bus.ireq_valid || m_streak < LIM)) begin
               m_busy = 1'b1; m_own_d = 1'b1;
               e_wr = bus.dreq_write; e_addr = bus.dreq_addr; e_size = bus.dreq_size;
               e_strb = bus.dreq_strobe; e_data = bus.dreq_data;
               m_streak = bus.ireq_valid ? ((m_streak + 1 > LIM) ? LIM : m_streak + 1) : 0;
            end else if (bus.ireq_valid) begin
               m_busy = 1'b1; m_own_d = 1'b0;
               e_wr = 1'b0; e_addr = bus.ireq_addr; e_size = 3'd3; e_strb = 8'd0; e_data = 64'd0;
               m_streak = 0;
            end else begin
               m_streak = 0;
            end
         end
         tick;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single memory bus between the instruction-fetch stage (read-only, 32-bit) and the memory stage (loads and stores of 8/16/32/64 bits).
- Sits between the pipeline and the memory/cache interface.
- Grants one outstanding transaction at a time and holds the grant until the bus responds.
- Data requests have priority, bounded by an anti-starvation counter that guarantees fetch progress.

Parameters:
- STARVE_LIMIT, 4: maximum number of consecutive data grants while a fetch request is pending; the next grant goes to fetch.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset (active when 0)
- ireq_valid  in  1  fetch request
- ireq_addr  in  64  fetch byte address
- iresp_data_ok  out  1  fetch completion pulse
- iresp_data  out  32  fetched instruction
- dreq_valid  in  1  memory-stage request
- dreq_write  in  1  1 = store
- dreq_addr  in  64  data address
- dreq_size  in  3  MemSize encoding: 1 = 8b, 2 = 16b, 3 = 32b, 4 = 64b
- dreq_strobe  in  8  byte enables (stores)
- dreq_data  in  64  store data
- dresp_data_ok  out  1  data completion pulse
- dresp_data  out  64  load data (raw 64-bit word)
- mreq_valid  out  1  bus request
- mreq_is_write  out  1  bus write
- mreq_addr  out  64  bus address
- mreq_size  out  3  bus size
- mreq_strobe  out  8  bus byte enables
- mreq_data  out  64  bus write data
- mresp_ready  in  1  bus completion, single beat
- mresp_data  in  64  bus read data

Behaviour:
- Reset (reset == 0 at a clk edge):
  - state = IDLE, streak = 0.
  - All mreq_* registers = 0; iresp_data_ok = dresp_data_ok = 0.
  - Reset wins over every other event, including mid-transaction. The aborted transaction produces no data_ok.
- States: IDLE, I_BUSY, D_BUSY.
- IDLE arbitration, evaluated each cycle:
  - Grant D if dreq_valid && (!ireq_valid || streak < STARVE_LIMIT).
  - Else grant I if ireq_valid.
  - Else stay in IDLE.
- On a grant, at the clk edge:
  - Latch the request into the mreq_* registers; mreq_valid = 1.
  - D grant: go to D_BUSY. mreq_* copy dreq_write/addr/size/strobe/data.
  - I grant: go to I_BUSY. mreq_is_write = 0, mreq_size = 3, mreq_strobe = 0, mreq_data = 0, mreq_addr = ireq_addr.
- Streak counter, updated only in IDLE:
  - D grant with ireq_valid = 1: streak + 1, saturating at STARVE_LIMIT.
  - I grant, or a cycle with ireq_valid = 0: streak = 0.
- Busy states:
  - mreq_* are held stable until mresp_ready.
  - Changes on the requester inputs are ignored; the latched copy drives the bus.
- Completion (BUSY && mresp_ready):
  - Owner's data_ok = 1 for exactly that cycle; it is a combinational function of state and mresp_ready.
  - dresp_data = mresp_data.
  - iresp_data = latched mreq_addr[2] ? mresp_data[63:32] : mresp_data[31:0].
  - Next edge: mreq_valid = 0, state = IDLE.
  - The non-owner's data_ok stays 0.
- Data outputs when no completion is in progress: iresp_data = dresp_data = 0.
- Latency: request sampled in IDLE at cycle N; mreq_valid is high at N+1; the earliest data_ok is at N+1 (ready in the first busy cycle).
  - There is one mandatory IDLE cycle between transactions.
- Requester protocol:
  - Hold valid and all fields until its data_ok cycle.
  - In the cycle after data_ok, either deassert valid or present the next request. No double issue can occur.
  - If a requester drops valid while owning the bus, the transaction still completes and data_ok still pulses.
- No size or alignment checking; the bus is responsible for that.

Test Plan:
1. Fetch only: ireq_valid, ireq_addr = 0x8000_0004; mresp_ready = 1 one cycle after mreq_valid, with mresp_data = 0xAABBCCDD_11223344 -> mreq_size = 3, mreq_strobe = 0; iresp_data = 0xAABBCCDD with a one-cycle iresp_data_ok; dresp_data_ok stays 0.
2. Simultaneous requests, streak 0: ireq and dreq (sd, addr 0x100, size 4, strobe 0xFF, data 0x0123456789ABCDEF) both valid -> the D transaction goes first with exact pass-through of the store fields, then IDLE, then the I transaction.
3. Starvation with STARVE_LIMIT = 4: dreq_valid and ireq_valid held high, instant ready -> grant order D, D, D, D, I, D; streak resets to 0 after the I grant.
4. Bus stall: mresp_ready held low 5 cycles in D_BUSY while dreq_addr toggles -> mreq_* constant; no data_ok until ready; then a single dresp_data_ok pulse.
5. Reset mid-operation: reset = 0 in the second D_BUSY cycle -> after that edge mreq_valid = 0, state IDLE, streak 0; no dresp_data_ok, even if mresp_ready is asserted in the same cycle.
6. Lower-word fetch: ireq_addr = 0x8000_0000, mresp_data = 0xAABBCCDD_11223344 -> iresp_data = 0x11223344.
